// File: rtl/video_pkg.sv
// Shared types and constants for the video timing checker.
package video_pkg;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned SUM_W   = 32;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/video_edge_det.sv
// Registers one sync input and flags its 1->0 transition.
module video_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic q,
  output logic fall_c
);

  logic q_prev;

  // Two-stage history; both stages reset high so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q      <= 1'b1;
      q_prev <= 1'b1;
    end else begin
      q      <= sig;
      q_prev <= q;
    end
  end

  assign fall_c = q_prev & ~q;

endmodule

// File: rtl/video_checker.sv
// Video timing checker: measures active pixels per line and active lines
// per frame against HDISP/VDISP and reports lock and sticky errors.
// Optional per-frame pixel sum output enabled by macro VIDEO_CHECKER_CRC_EN.
module video_checker
  import video_pkg::*;
#(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480
) (
  input  logic                   pixel_clk,
  input  logic                   pixel_rst_n,
  input  logic                   vid_hs,
  input  logic                   vid_vs,
  input  logic                   vid_blank,
  input  logic [RGB_W-1:0]       vid_rgb,
  input  logic                   err_clr,
  output logic                   locked,
  output logic [FRAME_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]       last_hcount,
  output logic [CNT_W-1:0]       last_vcount,
  output logic                   err_h,
  output logic                   err_v
`ifdef VIDEO_CHECKER_CRC_EN
  ,
  output logic [SUM_W-1:0]       frame_sum
`endif
);

  logic             hs_q;
  logic             vs_q;
  logic             hse;
  logic             vse;
  logic             blank_q;
  logic [RGB_W-1:0] rgb_q;

  state_t           state;
  state_t           state_next;
  logic             good_seen;
  logic             good_next;

  logic             synced;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] line_total;
  logic             line_done;
  logic             h_err_ev;
  logic             v_err_ev;
  logic             sync_unused;

  video_edge_det u_hs_det (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .sig    (vid_hs),
    .q      (hs_q),
    .fall_c (hse)
  );

  video_edge_det u_vs_det (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .sig    (vid_vs),
    .q      (vs_q),
    .fall_c (vse)
  );

  assign sync_unused = hs_q ^ vs_q;

  // Register the remaining video inputs once.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      blank_q <= 1'b1;
      rgb_q   <= '1;
    end else begin
      blank_q <= vid_blank;
      rgb_q   <= vid_rgb;
    end
  end

  // Line/frame events; a line closing on the VSE cycle is folded into the frame total.
  always_comb begin
    line_done  = synced && hse && (pix_cnt != '0);
    h_err_ev   = line_done && (pix_cnt != CNT_W'(HDISP));
    line_total = line_done ? sat_inc(line_cnt) : line_cnt;
    v_err_ev   = synced && vse && (line_total != CNT_W'(VDISP));
  end

  // Measurement counters, snapshots and sticky errors; nothing is measured until the first VSE.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      synced      <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      last_hcount <= '0;
      last_vcount <= '0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      if (vse) begin
        synced <= 1'b1;
      end

      if (hse) begin
        pix_cnt <= '0;
      end else if (synced && blank_q) begin
        pix_cnt <= sat_inc(pix_cnt);
      end

      if (line_done) begin
        last_hcount <= pix_cnt;
      end

      if (vse) begin
        line_cnt  <= '0;
        frame_cnt <= frame_cnt + FRAME_W'(1);
        if (synced) begin
          last_vcount <= line_total;
        end
      end else if (line_done) begin
        line_cnt <= sat_inc(line_cnt);
      end

      if (h_err_ev) begin
        err_h <= 1'b1;
      end else if (err_clr) begin
        err_h <= 1'b0;
      end

      if (v_err_ev) begin
        err_v <= 1'b1;
      end else if (err_clr) begin
        err_v <= 1'b0;
      end
    end
  end

  // Lock FSM state register, including the clean-VSE tally.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state     <= SEARCH;
      good_seen <= 1'b0;
    end else begin
      state     <= state_next;
      good_seen <= good_next;
    end
  end

  // Lock FSM next state: any new error restarts the clean-VSE run.
  always_comb begin
    state_next = state;
    good_next  = good_seen;
    case (state)
      SEARCH: begin
        if (vse) begin
          state_next = MEASURE;
          good_next  = 1'b0;
        end
      end
      MEASURE: begin
        if (h_err_ev || v_err_ev) begin
          good_next = 1'b0;
        end else if (vse) begin
          if (good_seen) begin
            state_next = LOCKED;
            good_next  = 1'b0;
          end else begin
            good_next = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (h_err_ev || v_err_ev) begin
          state_next = SEARCH;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = 1'b0;
      end
    endcase
  end

  // Lock FSM output decode.
  always_comb begin
    locked = (state == LOCKED);
  end

`ifdef VIDEO_CHECKER_CRC_EN
  logic [SUM_W-1:0] sum_acc;

  // Per-frame sum of active pixel data, latched and restarted at VSE.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (vse) begin
      frame_sum <= sum_acc;
      sum_acc   <= '0;
    end else if (synced && blank_q) begin
      sum_acc <= sum_acc + SUM_W'(rgb_q);
    end
  end
`else
  logic rgb_unused;
  assign rgb_unused = ^rgb_q;
`endif

endmodule

// File: tb/tb_video_checker.sv
// Directed bench for video_checker, 800 pixels x 4 lines per frame.
module tb_video_checker;

  localparam int unsigned HD = 800;
  localparam int unsigned VD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;
  logic        err_clr;
  logic        locked;
  logic [15:0] frame_cnt;
  logic [11:0] last_hcount;
  logic [11:0] last_vcount;
  logic        err_h;
  logic        err_v;
`ifdef VIDEO_CHECKER_CRC_EN
  logic [31:0] frame_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  video_checker #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .vid_hs      (hs),
    .vid_vs      (vs),
    .vid_blank   (blank),
    .vid_rgb     (rgb),
    .err_clr     (err_clr),
    .locked      (locked),
    .frame_cnt   (frame_cnt),
    .last_hcount (last_hcount),
    .last_vcount (last_vcount),
    .err_h       (err_h),
    .err_v       (err_v)
`ifdef VIDEO_CHECKER_CRC_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One line: sync pulse (optionally with vsync), back porch, npix active, front porch.
  task automatic send_line(input int npix, input logic with_vs);
    hs = 1'b0; vs = ~with_vs; blank = 1'b0;
    step(2);
    hs = 1'b1; vs = 1'b1;
    step(2);
    blank = 1'b1;
    step(npix);
    blank = 1'b0;
    step(2);
  endtask

  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) send_line(HD, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = 24'h000001; err_clr = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if ({locked, err_h, err_v} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {locked, err_h, err_v});
    end
    n_checks++;
    if ({frame_cnt, last_hcount, last_vcount} !== 40'd0) begin
      n_fail++; $display("FAIL reset_counts: got fc=%0d lh=%0d lv=%0d expected 0", frame_cnt, last_hcount, last_vcount);
    end
  endtask

  task automatic test_lock;
    send_line(0, 1'b1);
    send_lines(VD);
    send_line(0, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || frame_cnt !== 16'd2) begin
      n_fail++; $display("FAIL lock_vse2: got locked=%0d fc=%0d expected 0/2", locked, frame_cnt);
    end
    send_lines(VD);
    send_line(0, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_vse3: got locked=%0d expected 1", locked);
    end
    n_checks++;
    if (frame_cnt !== 16'd3) begin
      n_fail++; $display("FAIL lock_frame_cnt: got %0d expected 3", frame_cnt);
    end
    n_checks++;
    if (last_hcount !== 12'd800 || last_vcount !== 12'd4) begin
      n_fail++; $display("FAIL lock_counts: got lh=%0d lv=%0d expected 800/4", last_hcount, last_vcount);
    end
    n_checks++;
    if ({err_h, err_v} !== 2'b00) begin
      n_fail++; $display("FAIL lock_errs: got %b expected 00", {err_h, err_v});
    end
`ifdef VIDEO_CHECKER_CRC_EN
    n_checks++;
    if (frame_sum !== 32'd3200) begin
      n_fail++; $display("FAIL lock_frame_sum: got %0d expected 3200", frame_sum);
    end
`endif
  endtask

  task automatic test_line_error;
    send_line(799, 1'b0);
    hs = 1'b0;
    step(1);
    n_checks++;
    if (err_h !== 1'b0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL herr_early: got err_h=%0d locked=%0d expected 0/1", err_h, locked);
    end
    step(1);
    n_checks++;
    if (err_h !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL herr_hse2: got err_h=%0d locked=%0d expected 1/0", err_h, locked);
    end
    n_checks++;
    if (last_hcount !== 12'd799) begin
      n_fail++; $display("FAIL herr_hcount: got %0d expected 799", last_hcount);
    end
    hs = 1'b1;
    step(2);
    blank = 1'b1;
    step(HD);
    blank = 1'b0;
    step(2);
    send_lines(VD - 2);
    send_line(0, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'd4 || last_vcount !== 12'd4 || err_v !== 1'b0 || err_h !== 1'b1) begin
      n_fail++; $display("FAIL herr_vse4: got fc=%0d lv=%0d ev=%0d eh=%0d expected 4/4/0/1", frame_cnt, last_vcount, err_v, err_h);
    end
  endtask

  task automatic test_frame_error;
    send_lines(VD - 1);
    send_line(0, 1'b1);
    n_checks++;
    if (err_v !== 1'b1 || last_vcount !== 12'd3) begin
      n_fail++; $display("FAIL verr: got err_v=%0d lv=%0d expected 1/3", err_v, last_vcount);
    end
    n_checks++;
    if (frame_cnt !== 16'd5 || locked !== 1'b0) begin
      n_fail++; $display("FAIL verr_state: got fc=%0d locked=%0d expected 5/0", frame_cnt, locked);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_checks++;
    if ({err_h, err_v} !== 2'b00) begin
      n_fail++; $display("FAIL err_clr: got %b expected 00", {err_h, err_v});
    end
    send_lines(VD);
    send_line(0, 1'b1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL relock_early: got %0d expected 0", locked);
    end
    send_lines(VD);
    send_line(0, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || frame_cnt !== 16'd7 || last_vcount !== 12'd4) begin
      n_fail++; $display("FAIL relock: got locked=%0d fc=%0d lv=%0d expected 1/7/4", locked, frame_cnt, last_vcount);
    end
  endtask

  task automatic test_err_clr_priority;
    send_line(5, 1'b0);
    hs = 1'b0;
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_checks++;
    if (err_h !== 1'b1 || last_hcount !== 12'd5 || locked !== 1'b0) begin
      n_fail++; $display("FAIL clr_priority: got eh=%0d lh=%0d locked=%0d expected 1/5/0", err_h, last_hcount, locked);
    end
    hs = 1'b1;
    step(2);
    blank = 1'b1;
    step(HD);
    blank = 1'b0;
    step(2);
    send_lines(VD - 2);
  endtask

  task automatic test_reset_mid_line;
    hs = 1'b0;
    step(2);
    hs = 1'b1;
    step(2);
    blank = 1'b1;
    step(100);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    n_checks++;
    if ({locked, err_h, err_v} !== 3'b000 || {frame_cnt, last_hcount, last_vcount} !== 40'd0) begin
      n_fail++; $display("FAIL rst_mid: got locked=%0d eh=%0d ev=%0d fc=%0d lh=%0d lv=%0d expected all 0", locked, err_h, err_v, frame_cnt, last_hcount, last_vcount);
    end
    step(HD - 100);
    blank = 1'b0;
    step(2);
    send_line(HD, 1'b0);
    n_checks++;
    if (last_hcount !== 12'd0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_no_measure: got lh=%0d fc=%0d expected 0/0", last_hcount, frame_cnt);
    end
    send_line(0, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'd1 || last_vcount !== 12'd0 || err_v !== 1'b0) begin
      n_fail++; $display("FAIL rst_vse1: got fc=%0d lv=%0d ev=%0d expected 1/0/0", frame_cnt, last_vcount, err_v);
    end
    send_lines(VD);
    send_line(0, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'd2 || last_vcount !== 12'd4 || last_hcount !== 12'd800 || {err_h, err_v} !== 2'b00) begin
      n_fail++; $display("FAIL rst_resume: got fc=%0d lv=%0d lh=%0d errs=%b expected 2/4/800/00", frame_cnt, last_vcount, last_hcount, {err_h, err_v});
    end
`ifdef VIDEO_CHECKER_CRC_EN
    n_checks++;
    if (frame_sum !== 32'd3200) begin
      n_fail++; $display("FAIL rst_frame_sum: got %0d expected 3200", frame_sum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_line_error();
    test_frame_error();
    test_err_clr_priority();
    test_reset_mid_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_checker.md
VIDEO_CHECKER -- requirements
Module: video_checker

Interface
REQ-001 SHALL have parameter HDISP, default 800, meaning expected active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, meaning expected active lines per frame.
REQ-003 SHALL have port pixel_clk, input, 1, the single clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port pixel_rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port vid_hs, input, 1, horizontal sync, active-low.
REQ-006 SHALL have port vid_vs, input, 1, vertical sync, active-low.
REQ-007 SHALL have port vid_blank, input, 1, high = active pixel, low = blanking.
REQ-008 SHALL have port vid_rgb, input, 24, pixel data {R,G,B}.
REQ-009 SHALL have port err_clr, input, 1, single-cycle clear of the sticky error flags.
REQ-010 SHALL have port locked, output, 1, timing matches HDISP/VDISP.
REQ-011 SHALL have port frame_cnt, output, 16, count of completed frames, wraps 0xFFFF->0.
REQ-012 SHALL have port last_hcount, output, 12, active pixel count of the last active line.
REQ-013 SHALL have port last_vcount, output, 12, active line count of the last frame.
REQ-014 SHALL have port err_h and err_v, output, 1 each, sticky line-length and frame-height errors.

Function
REQ-015 SHALL register all video inputs once; edge detection SHALL use the registered value against its previous registered value.
REQ-016 SHALL treat a registered vid_hs 1->0 transition as line end/start (HSE) and vid_vs 1->0 as frame end/start (VSE).
REQ-017 SHALL count cycles with registered vid_blank=1 since the last HSE in a 12-bit pixel counter saturating at 4095.
REQ-018 At HSE with pixel counter nonzero: SHALL load last_hcount, increment the 12-bit line counter (saturating at 4095), set err_h if count != HDISP, and clear the pixel counter.
REQ-019 At HSE with pixel counter zero (blanking line): SHALL leave last_hcount and the line counter unchanged.
REQ-020 At VSE: SHALL load last_vcount from the line counter, set err_v if != VDISP, increment frame_cnt, and clear the line counter.
REQ-021 When HSE and VSE coincide, SHALL complete the line update of REQ-018 first, so that line is included in last_vcount.
REQ-022 Latency: outputs SHALL update 2 clock cycles after the falling edge appears at the ports.
REQ-023 SHALL implement the FSM SEARCH -> MEASURE on the first VSE; MEASURE -> LOCKED after 2 consecutive VSEs with no new line or frame error; LOCKED -> SEARCH on any line or frame error; locked=1 only in LOCKED.
REQ-024 A new error detected in the same cycle as err_clr SHALL win, leaving the flag set.

Reset
REQ-025 While pixel_rst_n=0 at a clock edge: FSM=SEARCH; all counters, outputs and the checksum register SHALL be 0; the input registers SHALL be 1 so that no spurious edge fires after reset.
REQ-026 Reset mid-frame SHALL discard partial counts; the next measurement SHALL start at the following VSE.

Configuration
REQ-027 With macro VIDEO_CHECKER_CRC_EN defined: SHALL add output frame_sum, 32 bits, the modulo-2^32 sum of vid_rgb over active pixels, latched at VSE, with the accumulator cleared at the same time.
REQ-028 Without VIDEO_CHECKER_CRC_EN: the frame_sum port and the accumulator SHALL be absent.

Structure
REQ-029 SHALL take the FSM state enum typedef and the counter width constant (12) from shared package video_pkg.
REQ-030 SHALL instantiate one sub-module, video_edge_det, one per sync signal, providing the registered value and the falling-edge pulse.

Verification
REQ-031 Stimulus: 800x480 timing for 3 frames -> locked=1 after the 3rd VSE; last_hcount=800; last_vcount=480; err_h=err_v=0; frame_cnt=3.
REQ-032 Stimulus: one line with 799 active pixels in frame 4 -> err_h=1 and locked=0 at that HSE+2; last_hcount=799.
REQ-033 Stimulus: frame with 479 active lines -> err_v=1, last_vcount=479; then err_clr pulse -> err_v=0; 2 more good frames -> locked=1.
REQ-034 Stimulus: HSE and VSE coincident after the last active line -> last_vcount=480.
REQ-035 Stimulus: pixel_rst_n=0 for 1 cycle mid-line -> all outputs 0; no HSE/VSE fires on release; counts resume after the next VSE.
REQ-036 Stimulus (VIDEO_CHECKER_CRC_EN): every pixel = 0x000001 for one 800x480 frame -> frame_sum=384000 (0x0005DC00).
